// File: rtl/m_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice (m_fetch, m_fetch_fifo).
package m_fetch_pkg;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN   = 1'b0;
  localparam fetch_state_t FLUSH = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Small FIFO with synchronous flush and occupancy count; the head entry is read combinationally.
module m_fetch_fifo
  import m_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Flush wins over a same-cycle push or pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/m_fetch.sv
// In-order instruction fetch with bounded in-flight requests, redirect flush and stale-response drop.
// Optional FETCH_PERF_EN adds delivered/squashed instruction counters.
module m_fetch
  import m_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic         w_redirect,
  input  logic [31:0]  w_redirect_pc,
  output logic         w_req_valid,
  output logic [31:0]  w_req_addr,
  input  logic         w_req_ready,
  input  logic         w_rsp_valid,
  input  logic [31:0]  w_rsp_data,
  output logic         w_inst_valid,
  output logic [31:0]  w_inst,
  output logic [31:0]  w_inst_pc,
  input  logic         w_inst_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0]  w_fetch_cnt,
  output logic [31:0]  w_squash_cnt,
`endif
  output fetch_state_t w_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and imem responses carry no ready (always accepted).
  localparam int unsigned CW       = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD_LIMIT = (CW + 1)'(QDEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] if_cnt, iq_cnt;
  logic [CW:0]   occupancy;
  logic [31:0]   if_head;
  fetch_entry_t  iq_head, iq_wdata;
  logic          req_fire, rsp_run, stale_drop, iq_pop, inst_vld;

  assign occupancy   = {1'b0, if_cnt} + {1'b0, iq_cnt};
  assign w_req_valid = !w_rst && (state_q == RUN) && !w_redirect && (occupancy < QD_LIMIT);
  assign w_req_addr  = pc_q;
  assign req_fire    = w_req_valid && w_req_ready;

  assign rsp_run    = w_rsp_valid && (state_q == RUN);
  assign stale_drop = w_rsp_valid && (state_q == FLUSH);
  assign iq_wdata   = '{pc: if_head, inst: w_rsp_data};

  // Redirect beats pop: the head is squashed rather than delivered.
  assign inst_vld     = (iq_cnt != '0);
  assign iq_pop       = inst_vld && w_inst_ready && !w_redirect;
  assign w_inst_valid = inst_vld;
  assign w_inst       = inst_vld ? iq_head.inst : '0;
  assign w_inst_pc    = inst_vld ? iq_head.pc : '0;
  assign w_dbg_state  = state_q;

  m_fetch_fifo #(.WIDTH(32), .DEPTH(QDEPTH)) u_inflight (
    .clk_i      (w_clk),
    .rst_i      (w_rst),
    .push_i     (req_fire),
    .push_data_i(pc_q),
    .pop_i      (w_rsp_valid),
    .flush_i    (1'b0),
    .head_o     (if_head),
    .count_o    (if_cnt)
  );

  m_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_iq (
    .clk_i      (w_clk),
    .rst_i      (w_rst),
    .push_i     (rsp_run),
    .push_data_i(iq_wdata),
    .pop_i      (iq_pop),
    .flush_i    (w_redirect),
    .head_o     (iq_head),
    .count_o    (iq_cnt)
  );

  // Stale count excludes the response retiring in the redirect cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    if (req_fire) pc_d = pc_q + INST_BYTES;
    if (w_redirect) begin
      pc_d    = word_align(w_redirect_pc);
      stale_d = ((state_q == FLUSH) ? stale_q : if_cnt) - CW'(w_rsp_valid);
      state_d = (stale_d != '0) ? FLUSH : RUN;
    end else if (stale_drop) begin
      stale_d = stale_q - CW'(1);
      if (stale_q == CW'(1)) state_d = RUN;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, squash_cnt_q, squash_inc;

  always_comb begin
    squash_inc = 32'(stale_drop);
    if (w_redirect) squash_inc = squash_inc + 32'(iq_cnt) + 32'(rsp_run);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + 32'(iq_pop);
      squash_cnt_q <= squash_cnt_q + squash_inc;
    end
  end

  assign w_fetch_cnt  = fetch_cnt_q;
  assign w_squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_m_fetch.sv
// Self-checking bench for m_fetch: randomized imem/execute traffic against an in-order delivery model.
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_m_fetch;
  import m_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  // Depth 4 lets a 1-cycle imem sustain one instruction per cycle.
  localparam int QD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready = 1'b0;
  logic         rsp_valid = 1'b0;
  logic [31:0]  rsp_data = '0;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_ready = 1'b0;
  fetch_state_t dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]  fetch_cnt, squash_cnt;
`endif

  m_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QD)) dut (
    .w_clk        (clk),
    .w_rst        (rst),
    .w_redirect   (redirect),
    .w_redirect_pc(redirect_pc),
    .w_req_valid  (req_valid),
    .w_req_addr   (req_addr),
    .w_req_ready  (req_ready),
    .w_rsp_valid  (rsp_valid),
    .w_rsp_data   (rsp_data),
    .w_inst_valid (inst_valid),
    .w_inst       (inst),
    .w_inst_pc    (inst_pc),
    .w_inst_ready (inst_ready),
`ifdef FETCH_PERF_EN
    .w_fetch_cnt  (fetch_cnt),
    .w_squash_cnt (squash_cnt),
`endif
    .w_dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // imem model: pending accepted requests, answered in order at least one cycle later
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  // scoreboard: addresses that must come out of the fetch unit, in order
  logic [31:0] exp_q[$];
  logic [31:0] exp_req;

  int cyc = 0;
  int knob_req = 100, knob_rsp = 100, knob_ird = 100, knob_redir = 0;
  bit force_redir = 1'b0;
  logic [31:0] force_tgt = '0;
  bit after_redir = 1'b0;
  int n_req = 0, n_stale = 0, n_deliv = 0, n_deliv_r = 0, n_rsp_r = 0;

  logic         s_req_valid, s_inst_valid;
  logic [31:0]  s_req_addr;
  fetch_state_t s_state;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFE0 | 32'($urandom_range(31));
    return $urandom();
  endfunction

  task automatic cycle();
    int pend_before;
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    pend_before = pend_addr.size();
    rsp_valid = 1'b0;
    rsp_data  = $urandom();
    if (pend_before > 0 && pend_cyc[0] < cyc && $urandom_range(99) < knob_rsp) begin
      rsp_valid = 1'b1;
      rsp_data  = data_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
      n_rsp_r++;
    end
    req_ready   = ($urandom_range(99) < knob_req);
    inst_ready  = ($urandom_range(99) < knob_ird);
    redirect    = force_redir || ($urandom_range(999) < knob_redir);
    redirect_pc = force_redir ? force_tgt : rand_target();
    force_redir = 1'b0;
    #1;
    s_req_valid  = req_valid;
    s_req_addr   = req_addr;
    s_inst_valid = inst_valid;
    s_state      = dbg_state;
    if (after_redir) check("inst_valid_after_redirect", 32'(inst_valid), 32'd0);
    if (redirect) check("req_valid_during_redirect", 32'(req_valid), 32'd0);
    if (req_valid) check("req_inflight_bound", 32'(pend_before < QD), 32'd1);
    if (req_valid && req_ready) begin
      check("req_addr", req_addr, exp_req);
      exp_q.push_back(exp_req);
      pend_addr.push_back(req_addr);
      pend_cyc.push_back(cyc);
      exp_req = exp_req + 32'd4;
      n_req++;
    end
    if (inst_valid && inst_ready && !redirect) begin
      check("delivery_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", inst, data_of(e));
      end
      n_deliv++;
      n_deliv_r++;
    end
    if (redirect) begin
      exp_req = redirect_pc & ~32'd3;
      exp_q.delete();
    end
    after_redir = redirect;
    if (rsp_valid && dbg_state == FLUSH) n_stale++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    inst_ready = 1'b0;
    #1;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(RUN));
`ifdef FETCH_PERF_EN
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_squash_cnt", squash_cnt, 32'd0);
`endif
    pend_addr.delete();
    pend_cyc.delete();
    exp_q.delete();
    exp_req = RESET_PC;
    after_redir = 1'b0;
    n_deliv_r = 0;
    n_rsp_r = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Stop fetching and let everything outstanding drain out to execute.
  task automatic drain();
    knob_req = 0; knob_rsp = 100; knob_ird = 100; knob_redir = 0;
    repeat (2 * QD + 6) cycle();
    check("drain_no_lost_entries", 32'(exp_q.size()), 32'd0);
    check("drain_inst_valid", 32'(s_inst_valid), 32'd0);
`ifdef FETCH_PERF_EN
    cycle();
    check("perf_fetch_cnt", fetch_cnt, 32'(n_deliv_r));
    check("perf_squash_cnt", squash_cnt, 32'(n_rsp_r - n_deliv_r));
`endif
  endtask

  initial begin
    bit seen;
    int d0;

    // Reset release, streaming with a 1-cycle imem
    do_reset();
    knob_req = 100; knob_rsp = 100; knob_ird = 100; knob_redir = 0;
    cycle();
    check("first_req_valid", 32'(s_req_valid), 32'd1);
    check("first_req_addr", s_req_addr, RESET_PC);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (seen) check("no_bubble", 32'(s_inst_valid), 32'd1);
      if (s_inst_valid) seen = 1'b1;
    end
    check("stream_filled", 32'(seen), 32'd1);
    drain();

    // Execute stalls: requests stop at QD outstanding, nothing lost afterwards
    do_reset();
    knob_req = 100; knob_rsp = 100; knob_ird = 0;
    n_req = 0;
    repeat (10) cycle();
    check("stall_req_count", 32'(n_req), 32'(QD));
    check("stall_req_valid_low", 32'(s_req_valid), 32'd0);
    drain();

    // Redirect with two requests in flight: both responses dropped, refetch aligned target
    do_reset();
    knob_req = 100; knob_rsp = 0; knob_ird = 100;
    n_req = 0;
    cycle();
    cycle();
    check("two_in_flight", 32'(n_req), 32'd2);
    force_redir = 1'b1; force_tgt = 32'h0000_0043;
    cycle();
    knob_rsp = 100;
    n_stale = 0;
    cycle();
    check("flush_state_1", 32'(s_state), 32'(FLUSH));
    check("flush_no_req_1", 32'(s_req_valid), 32'd0);
    cycle();
    check("flush_state_2", 32'(s_state), 32'(FLUSH));
    check("flush_no_req_2", 32'(s_req_valid), 32'd0);
    cycle();
    check("flush_exit_state", 32'(s_state), 32'(RUN));
    check("flush_exit_req_valid", 32'(s_req_valid), 32'd1);
    check("flush_exit_req_addr", s_req_addr, 32'h0000_0040);
    check("stale_dropped", 32'(n_stale), 32'd2);
    repeat (6) cycle();
    drain();

    // Redirect coincident with a response and a pop
    do_reset();
    knob_req = 100; knob_rsp = 100; knob_ird = 100;
    repeat (5) cycle();
    force_redir = 1'b1; force_tgt = 32'h0000_0200;
    cycle();
    check("coincident_head_valid", 32'(s_inst_valid), 32'd1);
    cycle();
    check("coincident_queue_empty", 32'(s_inst_valid), 32'd0);
    repeat (8) cycle();
    drain();

    // PC wraps from the top of the address space
    do_reset();
    knob_req = 0;
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
    cycle();
    knob_req = 100; knob_rsp = 100; knob_ird = 100;
    cycle();
    check("wrap_addr_top", s_req_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_addr_zero", s_req_addr, 32'h0000_0000);
    repeat (4) cycle();
    drain();

`ifdef FETCH_PERF_EN
    // Counters: deliver five, squash the rest, then reset mid-burst
    do_reset();
    knob_req = 100; knob_rsp = 100; knob_ird = 100;
    for (int i = 0; i < 40 && n_deliv_r < 5; i++) cycle();
    knob_ird = 0;
    cycle();
    check("perf_five_delivered", fetch_cnt, 32'd5);
    force_redir = 1'b1; force_tgt = 32'h0000_1000;
    cycle();
    drain();
    knob_req = 100; knob_ird = 100;
    repeat (5) cycle();
    do_reset();
`endif

    // Randomized traffic with redirects and one mid-burst reset
    for (int r = 0; r < 4; r++) begin
      do_reset();
      knob_req   = $urandom_range(100, 30);
      knob_rsp   = $urandom_range(100, 20);
      knob_ird   = $urandom_range(100, 20);
      knob_redir = $urandom_range(60, 5);
      d0 = n_deliv;
      for (int i = 0; i < 600; i++) begin
        cycle();
        if (r == 1 && i == 300) begin
          do_reset();
          knob_redir = $urandom_range(60, 5);
        end
      end
      check("random_progress", 32'(n_deliv > d0), 32'd1);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_fetch.md
M_FETCH -- requirements
Module: m_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter QDEPTH, default 2, the instruction queue depth (power of two, 2..8).
REQ-003 The block SHALL have port w_clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port w_rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port w_redirect  in  1  PC redirect from execute (taken branch, jal, jalr).
REQ-006 The block SHALL have port w_redirect_pc  in  32  redirect target address.
REQ-007 The block SHALL have port w_req_valid  out  1  imem fetch request valid.
REQ-008 The block SHALL have port w_req_addr  out  32  imem fetch address, word aligned.
REQ-009 The block SHALL have port w_req_ready  in  1  imem accepts the request.
REQ-010 The block SHALL have port w_rsp_valid  in  1  imem response valid; responses arrive in request order, one per accepted request, at least 1 cycle after acceptance.
REQ-011 The block SHALL have port w_rsp_data  in  32  fetched instruction word.
REQ-012 The block SHALL have port w_inst_valid  out  1  instruction available to execute.
REQ-013 The block SHALL have port w_inst  out  32  instruction at queue head.
REQ-014 The block SHALL have port w_inst_pc  out  32  PC of w_inst.
REQ-015 The block SHALL have port w_inst_ready  in  1  execute consumes head this cycle.

Function
REQ-016 A request SHALL transfer when w_req_valid and w_req_ready are both high on a rising edge; the fetch PC SHALL then advance by 4, wrapping modulo 2^32.
REQ-017 w_req_valid SHALL be high only in state RUN, with w_redirect low, and with (in-flight count + queue count) < QDEPTH.
REQ-018 Each accepted address SHALL be held in an in-flight address FIFO of depth QDEPTH; on w_rsp_valid in RUN, the head address and w_rsp_data SHALL be pushed as one entry into the instruction queue.
REQ-019 w_inst_valid SHALL equal queue non-empty, and the head SHALL pop when w_inst_valid and w_inst_ready are both high; push and pop in the same cycle SHALL both take effect.
REQ-020 The FSM SHALL have states RUN and FLUSH.
REQ-021 On w_redirect, the block SHALL set fetch PC <= {w_redirect_pc[31:2],2'b00}, empty the instruction queue (including any same-cycle push), and load the stale counter with the in-flight count, excluding any response arriving that cycle.
REQ-022 On w_redirect, the next state SHALL be FLUSH if the stale counter load is nonzero, else RUN.
REQ-023 In FLUSH, each w_rsp_valid SHALL be discarded, and the stale counter and in-flight FIFO SHALL decrement; on the last stale response the state SHALL return to RUN, with requests resuming the following cycle.
REQ-024 A redirect while in FLUSH SHALL update the PC and stay in FLUSH; the stale count SHALL be unchanged except for that cycle's response.
REQ-025 w_redirect SHALL take priority over pop: w_inst_valid SHALL be low in the cycle after any redirect.

Reset
REQ-026 While w_rst is high: PC=RESET_PC, state RUN, queue, in-flight FIFO and stale counter empty/zero, and w_req_valid=0, w_inst_valid=0, w_inst=0, w_inst_pc=0.
REQ-027 The first request SHALL be issued in the first cycle after w_rst deasserts; reset mid-operation SHALL discard all queued and in-flight state, and later responses to pre-reset requests are out of contract.

Configuration
REQ-028 With FETCH_PERF_EN defined, the block SHALL add outputs w_fetch_cnt and w_squash_cnt (each out, 32 bits), counting delivered instructions and discarded entries (queue flushes plus stale responses); both reset to 0 and wrap.
REQ-029 With FETCH_PERF_EN undefined, those ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (RUN, FLUSH), the fetch entry struct {pc[31:0], inst[31:0]}, and constant INST_BYTES=4.
REQ-031 One sub-module, m_fetch_fifo (parameterised width/depth, push/pop/flush, count output), SHALL be instantiated twice: once for in-flight addresses and once for the instruction queue.

Verification
REQ-032 Reset release, imem always ready, 1-cycle response, w_inst_ready=1 -> w_inst_pc sequence 0,4,8,12, no bubbles after fill.
REQ-033 w_inst_ready=0 for 10 cycles -> exactly QDEPTH requests issued, w_req_valid low thereafter, no entry lost when ready returns.
REQ-034 Redirect to 32'h0000_0043 with 2 in flight -> FLUSH for 2 responses, both dropped, next request address 32'h0000_0040.
REQ-035 Redirect coincident with response and pop -> response dropped, queue empty next cycle, w_inst_valid=0.
REQ-036 PC 32'hFFFF_FFFC fetched -> next request address 32'h0000_0000.
REQ-037 FETCH_PERF_EN build, 5 delivered and 3 squashed -> w_fetch_cnt=5, w_squash_cnt=3; w_rst asserted mid-burst -> both 0 and outputs at reset values.
